// File: rtl/cistercian_scan_ctrl.sv
// Scan controller for a dual Cistercian quadrant decoder: alternates low/high digit pairs with blanking,
// lamp test and a valid/ready shadow-register load. Optional macro BRIGHTNESS_EN adds PWM dimming of bi.
module cistercian_scan_ctrl #(
    parameter int DWELL        = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 10
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef BRIGHTNESS_EN
    input  logic [2:0]  brightness,
`endif
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        lt_req,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic        lt1,
    output logic        lt2,
    output logic        bi,
    output logic [1:0]  pair_sel,
    output logic        frame_done,
    output logic        bcd_err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BLANK_LO = 3'd1,
        S_SHOW_LO  = 3'd2,
        S_BLANK_HI = 3'd3,
        S_SHOW_HI  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic bcd_invalid(input logic [15:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = r | (v[4*i +: 4] > 4'd9);
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      display_q, display_d, shadow_q, shadow_d;
    logic             pending_q, pending_d, lt_lat_q, lt_lat_d;
    logic             load_ready_q, load_ready_d;
    logic [3:0]       dig1_q, dig1_d, dig2_q, dig2_d;
    logic             lt_q, lt_d, bi_q, bi_d;
    logic [1:0]       pair_sel_q, pair_sel_d;
    logic             frame_done_q, frame_done_d, bcd_err_q, bcd_err_d;
    logic             boundary_s, commit_pt_s, xfer_s, show_bi_s;

    // State sequencing: counter reloads on every state entry, enable low aborts to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_BLANK_LO;
                    cnt_d   = BLANK_LOAD;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_BLANK_LO, S_SHOW_LO, S_BLANK_HI, S_SHOW_HI: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    case (state_q)
                        S_BLANK_LO: begin state_d = S_SHOW_LO;  cnt_d = DWELL_LOAD; end
                        S_SHOW_LO:  begin state_d = S_BLANK_HI; cnt_d = BLANK_LOAD; end
                        S_BLANK_HI: begin state_d = S_SHOW_HI;  cnt_d = DWELL_LOAD; end
                        default:    begin state_d = S_BLANK_LO; cnt_d = BLANK_LOAD; end
                    endcase
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Load handshake, commit of shadow to display at frame boundaries / in IDLE, lamp-test latch
    always_comb begin
        boundary_s   = (state_q == S_SHOW_HI) && (cnt_q == '0) && enable;
        commit_pt_s  = (state_q == S_IDLE) || boundary_s;
        xfer_s       = load_valid & load_ready_q;
        display_d    = display_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        lt_lat_d     = lt_lat_q;
        if (xfer_s) begin
            if (commit_pt_s) begin
                display_d = bcd_sanitize(load_data);
            end else begin
                shadow_d  = bcd_sanitize(load_data);
                pending_d = 1'b1;
            end
        end else if (pending_q && commit_pt_s) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (boundary_s || ((state_q == S_IDLE) && enable)) begin
            lt_lat_d = lt_req;
        end else begin
            lt_lat_d = lt_lat_q;
        end
        load_ready_d = ~pending_d;
        frame_done_d = boundary_s;
        bcd_err_d    = xfer_s & bcd_invalid(load_data);
    end

`ifdef BRIGHTNESS_EN
    logic [31:0] elapsed_s, thresh_s;
    // Dimming: lit only for the first (brightness+1)/8 of the dwell
    always_comb begin
        elapsed_s = 32'(DWELL - 1) - 32'(cnt_d);
        thresh_s  = ((32'(brightness) + 32'd1) * 32'(DWELL)) >> 3;
        show_bi_s = (elapsed_s < thresh_s);
    end
`else
    assign show_bi_s = 1'b1;
`endif

    // Outputs are computed from the next state so the registers line up with the state they describe
    always_comb begin
        dig1_d     = dig1_q;
        dig2_d     = dig2_q;
        bi_d       = 1'b0;
        pair_sel_d = 2'b00;
        lt_d       = 1'b1;
        case (state_d)
            S_BLANK_LO, S_SHOW_LO: begin
                dig1_d     = display_d[3:0];
                dig2_d     = display_d[7:4];
                lt_d       = ~lt_lat_d;
                bi_d       = (state_d == S_SHOW_LO) ? show_bi_s : 1'b0;
                pair_sel_d = (state_d == S_SHOW_LO) ? 2'b01 : 2'b00;
            end
            S_BLANK_HI, S_SHOW_HI: begin
                dig1_d     = display_d[11:8];
                dig2_d     = display_d[15:12];
                lt_d       = ~lt_lat_d;
                bi_d       = (state_d == S_SHOW_HI) ? show_bi_s : 1'b0;
                pair_sel_d = (state_d == S_SHOW_HI) ? 2'b10 : 2'b00;
            end
            default: begin
                dig1_d = dig1_q;
                dig2_d = dig2_q;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            display_q    <= 16'd0;
            shadow_q     <= 16'd0;
            pending_q    <= 1'b0;
            lt_lat_q     <= 1'b0;
            load_ready_q <= 1'b1;
            dig1_q       <= 4'd0;
            dig2_q       <= 4'd0;
            lt_q         <= 1'b1;
            bi_q         <= 1'b0;
            pair_sel_q   <= 2'b00;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            lt_lat_q     <= lt_lat_d;
            load_ready_q <= load_ready_d;
            dig1_q       <= dig1_d;
            dig2_q       <= dig2_d;
            lt_q         <= lt_d;
            bi_q         <= bi_d;
            pair_sel_q   <= pair_sel_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign load_ready = load_ready_q;
    assign dig1       = dig1_q;
    assign dig2       = dig2_q;
    assign lt1        = lt_q;
    assign lt2        = lt_q;
    assign bi         = bi_q;
    assign pair_sel   = pair_sel_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_cistercian_scan_ctrl.sv
// Bench for cistercian_scan_ctrl: table vectors, directed corner sequences and random stimulus
// checked every cycle against a frame-position reference model.
module tb_cistercian_scan_ctrl;

    localparam int DW = 8;
    localparam int BL = 2;
    localparam int F  = 2 * (DW + BL);

    logic        clk = 1'b0;
    logic        rst_n, enable, load_valid, lt_req;
    logic [15:0] load_data;
    logic        load_ready, lt1, lt2, bi, frame_done, bcd_err;
    logic [3:0]  dig1, dig2;
    logic [1:0]  pair_sel;

    int errors = 0;
    int checks = 0;

    cistercian_scan_ctrl #(.DWELL(DW), .BLANK_CYCLES(BL), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
        .load_ready(load_ready), .load_data(load_data), .lt_req(lt_req),
        .dig1(dig1), .dig2(dig2), .lt1(lt1), .lt2(lt2), .bi(bi),
        .pair_sel(pair_sel), .frame_done(frame_done), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    // Reference model: position within a frame of F cycles
    bit          m_idle, m_pend, m_lt_lat, m_fd, m_err;
    int          m_pos;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_d1, m_d2;
    logic        m_bi;
    logic [1:0]  m_ps;

    localparam logic [15:0] RESET_VEC = {1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_pos = 0; m_pend = 0; m_lt_lat = 0; m_fd = 0; m_err = 0;
        m_disp = 16'd0; m_shadow = 16'd0; m_d1 = 4'd0; m_d2 = 4'd0; m_bi = 1'b0; m_ps = 2'b00;
    endtask

    function automatic logic [15:0] act_vec();
        return {load_ready, dig1, dig2, lt1, lt2, bi, pair_sel, frame_done, bcd_err};
    endfunction

    function automatic logic [15:0] exp_vec();
        logic lt;
        lt = m_idle ? 1'b1 : ~m_lt_lat;
        return {~m_pend, m_d1, m_d2, lt, lt, m_bi, m_ps, m_fd, m_err};
    endfunction

    task automatic step(input bit en, input bit lv, input logic [15:0] ld, input bit lt);
        bit xfer, bnd, cp, hi, show;
        enable = en; load_valid = lv; load_data = ld; lt_req = lt;
        @(posedge clk);
        xfer  = lv && !m_pend;
        bnd   = !m_idle && en && (m_pos == F - 1);
        cp    = m_idle || bnd;
        m_err = xfer && (sanitize(ld) != ld);
        m_fd  = bnd;
        if (xfer) begin
            if (cp) m_disp = sanitize(ld);
            else begin m_shadow = sanitize(ld); m_pend = 1; end
        end else if (m_pend && cp) begin
            m_disp = m_shadow; m_pend = 0;
        end
        if (!en) m_idle = 1;
        else if (m_idle) begin m_idle = 0; m_pos = 0; m_lt_lat = lt; end
        else begin
            m_pos = (m_pos + 1) % F;
            if (m_pos == 0) m_lt_lat = lt;
        end
        if (m_idle) begin
            m_bi = 1'b0; m_ps = 2'b00;
        end else begin
            hi   = (m_pos >= BL + DW);
            show = ((m_pos % (BL + DW)) >= BL);
            m_d1 = hi ? m_disp[11:8]  : m_disp[3:0];
            m_d2 = hi ? m_disp[15:12] : m_disp[7:4];
            m_bi = show;
            m_ps = !show ? 2'b00 : (hi ? 2'b10 : 2'b01);
        end
        #1;
        check("cycle", act_vec(), exp_vec());
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < F && m_pos != pos; k++) step(1, 0, 16'd0, 0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  lo1, lo2, hi1, hi2;
        logic        err;
    } vec_t;

    vec_t tbl[5];
    int   fd_cnt;
    bit   lt_s;

    initial begin
        tbl[0] = '{16'h4321, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0};
        tbl[1] = '{16'h9876, 4'd6, 4'd7, 4'd8, 4'd9, 1'b0};
        tbl[2] = '{16'h1A2F, 4'd0, 4'd2, 4'd0, 4'd1, 1'b1};
        tbl[3] = '{16'hFFFF, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1};
        tbl[4] = '{16'h0909, 4'd9, 4'd0, 4'd9, 4'd0, 1'b0};

        rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_data = 16'd0; lt_req = 1'b0;
        model_reset();
        #12;
        check("reset", act_vec(), RESET_VEC);
        rst_n = 1'b1;

        // Table vectors: load in IDLE, then inspect both pairs of the first frame
        foreach (tbl[i]) begin
            step(0, 0, 16'd0, 0);
            step(0, 1, tbl[i].data, 0);
            check("tbl_err", bcd_err, tbl[i].err);
            step(1, 0, 16'd0, 0);
            check("tbl_lo", {dig1, dig2}, {tbl[i].lo1, tbl[i].lo2});
            repeat (BL + DW) step(1, 0, 16'd0, 0);
            check("tbl_hi", {dig1, dig2}, {tbl[i].hi1, tbl[i].hi2});
            step(0, 0, 16'd0, 0);
        end

        // Frame period with 0x4321
        step(0, 1, 16'h4321, 0);
        step(1, 0, 16'd0, 0);
        fd_cnt = 0;
        repeat (2 * F) begin
            step(1, 0, 16'd0, 0);
            fd_cnt += int'(frame_done);
        end
        check("frame_done_count", fd_cnt, 2);

        // Mid-frame load is held in shadow until the boundary
        run_to(5);
        step(1, 1, 16'h9876, 0);
        check("midload_ready", load_ready, 1'b0);
        run_to(F - 2);
        check("midload_hold", {dig1, dig2}, {4'd3, 4'd4});
        step(1, 0, 16'd0, 0);
        step(1, 0, 16'd0, 0);
        check("midload_commit", {load_ready, dig1, dig2}, {1'b1, 4'd6, 4'd7});

        // Load coincident with the boundary cycle commits directly
        run_to(F - 1);
        step(1, 1, 16'h5555, 0);
        check("bnd_load", {load_ready, dig1, frame_done}, {1'b1, 4'd5, 1'b1});

        // Lamp test raised mid-frame, lowered mid next frame
        run_to(5);
        for (int k = 0; k < F; k++) step(1, 0, 16'd0, 1);
        check("lt_active", {lt1, lt2}, 2'b00);
        run_to(F - 1);
        step(1, 0, 16'd0, 0);
        check("lt_release", {lt1, lt2}, 2'b11);

        // Enable dropped during SHOW_HI
        run_to(14);
        step(0, 0, 16'd0, 0);
        check("drop_idle", {bi, pair_sel, frame_done}, 4'b0000);
        step(1, 0, 16'd0, 0);
        check("restart_blank_lo", {bi, pair_sel, dig1}, {1'b0, 2'b00, 4'd5});

        // Asynchronous reset mid-frame discards a pending value
        run_to(4);
        step(1, 1, 16'h2468, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset", act_vec(), RESET_VEC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 16'd0, 0);
        step(1, 0, 16'd0, 0);
        check("reset_lost_pending", {dig1, dig2}, 8'h00);

        // Random stimulus against the model
        lt_s = 0;
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 99) < 3) lt_s = ~lt_s;
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 25, 16'($urandom), lt_s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cistercian_scan_ctrl.md
Name: cistercian_scan_ctrl

Overview:
Time-multiplexing scan controller for the dual Cistercian quadrant decoder. It holds a 4-digit BCD value (units, tens, hundreds, thousands) and alternates the decoder between the low pair (units→channel 1, tens→channel 2) and the high pair (hundreds→channel 1, thousands→channel 2). It drives a one-hot common-line select and inserts blanking gaps between pairs to prevent ghosting. It also sequences lamp test and accepts new values via a valid/ready shadow-register handshake.

Parameters:
DWELL, 1000, clock cycles each pair is shown (≥1)
BLANK_CYCLES, 4, clock cycles of blanking before each pair (≥1)
CNT_W, 10, counter width; must hold max(DWELL, BLANK_CYCLES)−1

Ports:
clk  in  1  system clock
rst_n  in  1  reset
enable  in  1  scanning enabled
load_valid  in  1  new value offered
load_ready  out  1  shadow register free
load_data  in  16  {thou,hund,tens,units}, 4-bit BCD each
lt_req  in  1  lamp-test request (level)
dig1  out  4  decoder channel-1 value {D1,C1,B1,A1}
dig2  out  4  decoder channel-2 value {D2,C2,B2,A2}
lt1, lt2  out  1 each  lamp test to decoder, active-low
bi  out  1  blanking input to decoder, 1 = lit
pair_sel  out  2  one-hot common enable, [0] = low pair, [1] = high pair
frame_done  out  1  one-cycle pulse per completed frame
bcd_err  out  1  one-cycle pulse when an accepted nibble is > 9

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE; display and shadow registers 0; pending 0; counter 0.
  - load_ready 1; dig1 = dig2 = 0; lt1 = lt2 = 1; bi 0; pair_sel 00; frame_done 0; bcd_err 0.
- All outputs are registered.
- States and transitions:
  - IDLE: enable = 1 → BLANK_LO.
  - BLANK_LO → SHOW_LO → BLANK_HI → SHOW_HI → BLANK_LO.
  - BLANK_x lasts BLANK_CYCLES cycles; SHOW_x lasts DWELL cycles. The counter reloads on every state entry.
- Outputs per state:
  - IDLE: bi 0, pair_sel 00, dig held.
  - BLANK_LO: dig1 = units, dig2 = tens, bi 0, pair_sel 00 (data set up while dark).
  - SHOW_LO: same digits, bi 1, pair_sel 01.
  - BLANK_HI / SHOW_HI: dig1 = hund, dig2 = thou; bi 0 / 1; pair_sel 00 / 10.
- enable = 0 in any scanning state → IDLE on the next edge; the in-progress frame is abandoned, no frame_done.
- Frame boundary = transition SHOW_HI → BLANK_LO. frame_done pulses in the first BLANK_LO cycle.
- Handshake:
  - Transfer occurs when load_valid & load_ready. load_data goes into the shadow register, pending is set, and load_ready drops the next cycle.
  - Any nibble > 9 is stored as 0, and bcd_err pulses on the cycle after the transfer.
- Commit:
  - At a frame boundary, or on any cycle in IDLE, if pending: display ← shadow, pending cleared, load_ready returns to 1 the following cycle.
  - A transfer in the same cycle as a boundary (or while in IDLE) commits directly to display, bypassing pending; load_ready stays 1.
  - The display value never changes mid-frame.
- Lamp test:
  - lt_req is sampled at each boundary and on IDLE→BLANK_LO. While the latched value is 1, lt1 = lt2 = 0 for the whole next frame. Pair sequencing is unchanged.
  - lt_req is ignored in IDLE; lt1/lt2 stay 1 there.
- Reset mid-frame: outputs return to reset values immediately; any pending value is lost.

Optional Feature:
Macro BRIGHTNESS_EN.
- Defined: adds input brightness[2:0]. Within each SHOW state, bi = 1 only while the dwell counter's elapsed count is < (brightness+1)*DWELL/8 (integer division). brightness = 7 gives full on. Sequencing and timing are otherwise unchanged.
- Undefined: no port; bi = 1 for the whole SHOW state.

Test Plan:
- Reset, load 0x4321, enable with DWELL=8, BLANK=2 → BLANK_LO 2 cycles with dig1=1, dig2=2, bi=0; SHOW_LO 8 cycles with pair_sel=01, bi=1; BLANK_HI with dig1=3, dig2=4; frame_done every 20 cycles.
- Mid-frame load 0x9876 → load_ready=0 the next cycle; digits stay 4321 until the boundary, then 6/7 then 8/9; load_ready=1 the cycle after commit.
- Load 0x1A2F → bcd_err one pulse; displayed value 0x1020.
- lt_req=1 from mid-frame → lt1=lt2=0 from the next boundary for one full frame; deassert → 1 at the following boundary.
- enable dropped during SHOW_HI → next cycle IDLE, bi=0, pair_sel=00, no frame_done; re-enable restarts at BLANK_LO.
- load_valid coincident with boundary cycle → new digits appear in that BLANK_LO; load_ready never drops.
